// File: rtl/vector_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vector_assembler
// Purpose  : Packs a scalar trace stream (one element per cycle) into N-lane
//            vectors. Each completed vector is held in a one-entry output
//            register and offered to the input buffer's write interface with
//            backpressure. A nonzero end-of-frame code closes a vector early,
//            and the lanes that were not filled are set to PAD_VALUE.
// Ports    : clk, reset_n      - clock / asynchronous active-low reset
//            tracing           - 1 = accept elements
//            elem_valid/elem_in/elem_eof/elem_ready - scalar source handshake
//            vec_ready         - downstream can take a vector
//            enqueue/eof_out/vector_out - presented vector (lane 0 = first)
//            fill_level        - lanes currently held in the accumulator
//            vec_count         - saturating count of transferred vectors
// Revision : 1.0 - initial release
// ============================================================================
module vector_assembler #(
  parameter int                    N          = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tracing,
  input  logic                          elem_valid,
  input  logic [DATA_WIDTH-1:0]         elem_in,
  input  logic [1:0]                    elem_eof,
  output logic                          elem_ready,
  input  logic                          vec_ready,
  output logic                          enqueue,
  output logic [1:0]                    eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic [$clog2(N):0]            fill_level,
  output logic [CNT_WIDTH-1:0]          vec_count
);

  localparam int IDX_W = $clog2(N) + 1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t                   state, state_nx;
  logic [IDX_W-1:0]             fill_idx;
  logic [N-1:0][DATA_WIDTH-1:0] acc;
  logic [N-1:0][DATA_WIDTH-1:0] closed_vec;
  logic                         accept;
  logic                         last_lane;
  logic                         close;
  logic                         transfer;

  assign enqueue    = (state == FULL);
  // A new element may enter while the output register is being drained,
  // which is what allows back-to-back vectors without a bubble.
  assign elem_ready = tracing & (~enqueue | vec_ready);
  assign accept     = elem_valid & elem_ready;
  assign last_lane  = (fill_idx == IDX_W'(N - 1));
  assign close      = accept & (last_lane | (elem_eof != 2'b00));
  assign transfer   = enqueue & vec_ready;
  assign fill_level = fill_idx;

  // Vector as it will look once the current element is added: lanes below
  // the fill index come from the accumulator, the current lane takes the
  // incoming element, and everything above is padding.
  always_comb begin
    closed_vec = acc;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == fill_idx) begin
        closed_vec[i] = elem_in;
      end else if (IDX_W'(i) > fill_idx) begin
        closed_vec[i] = PAD_VALUE;
      end
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // A close while draining keeps the register FULL with the new vector.
  always_comb begin
    state_nx = state;
    if (close) begin
      state_nx = FULL;
    end else if (transfer) begin
      state_nx = EMPTY;
    end
  end

  // Accumulator, output payload and counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_idx   <= '0;
      eof_out    <= 2'b00;
      vector_out <= '0;
      vec_count  <= '0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= PAD_VALUE;
      end
    end else begin
      if (accept) begin
        if (close) begin
          fill_idx <= '0;
          for (int i = 0; i < N; i++) begin
            acc[i] <= PAD_VALUE;
          end
        end else begin
          fill_idx <= fill_idx + 1'b1;
          for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == fill_idx) begin
              acc[i] <= elem_in;
            end
          end
        end
      end

      if (close) begin
        vector_out <= closed_vec;
        eof_out    <= elem_eof;
      end else if (transfer) begin
        // Keep eof_out at 00 whenever nothing is presented.
        eof_out <= 2'b00;
      end

      if (transfer && (vec_count != {CNT_WIDTH{1'b1}})) begin
        vec_count <= vec_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vector_assembler
// Purpose  : Self-checking bench for vector_assembler. A lane model builds the
//            expected vectors as elements are accepted and pushes them to a
//            scoreboard queue; a monitor pops and compares on every transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_assembler;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int VW = N * DW;

  logic                  clk;
  logic                  reset_n;
  logic                  tracing;
  logic                  elem_valid;
  logic [DW-1:0]         elem_in;
  logic [1:0]            elem_eof;
  logic                  elem_ready;
  logic                  vec_ready;
  logic                  enqueue;
  logic [1:0]            eof_out;
  logic [N-1:0][DW-1:0]  vector_out;
  logic [3:0]            fill_level;
  logic [15:0]           vec_count;

  vector_assembler #(
    .N          (N),
    .DATA_WIDTH (DW),
    .PAD_VALUE  ('0),
    .CNT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tracing    (tracing),
    .elem_valid (elem_valid),
    .elem_in    (elem_in),
    .elem_eof   (elem_eof),
    .elem_ready (elem_ready),
    .vec_ready  (vec_ready),
    .enqueue    (enqueue),
    .eof_out    (eof_out),
    .vector_out (vector_out),
    .fill_level (fill_level),
    .vec_count  (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic [1:0]    eof;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] tb_acc [N];
  int            tb_idx = 0;
  logic [15:0]   exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane model: builds expected vectors from accepted elements.
  task automatic model_accept(input logic [DW-1:0] d, input logic [1:0] e);
    logic [VW-1:0] v;
    tb_acc[tb_idx] = d;
    if (tb_idx == N - 1 || e != 2'b00) begin
      v = '0;
      for (int i = 0; i <= tb_idx; i++) v[i*DW +: DW] = tb_acc[i];
      sbq.push_back('{vec: v, eof: e});
      tb_idx = 0;
    end else begin
      tb_idx++;
    end
  endtask

  // Offer one element; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] e);
    int n;
    n = 0;
    elem_valid = 1'b1;
    elem_in    = d;
    elem_eof   = e;
    @(negedge clk);
    check("fill_level", fill_level, tb_idx);
    while (!elem_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!elem_ready) check("accept_timeout", 0, 1);
    else model_accept(d, e);
    @(posedge clk);
    #1;
    elem_valid = 1'b0;
  endtask

  // Monitor: compare each transferred vector against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (enqueue && vec_ready) begin
        check("vec_count", vec_count, exp_count);
        if (sbq.size() == 0) begin
          check("unexpected_vec", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("vector", vector_out, mon_e.vec);
          check("eof_out", eof_out, mon_e.eof);
        end
        if (exp_count != 16'hFFFF) exp_count = exp_count + 1'b1;
      end else if (!enqueue) begin
        check("eof_idle", eof_out, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] held;
    logic [15:0]   c0;
    int            t0;

    reset_n = 1'b0; tracing = 1'b1; elem_valid = 1'b0;
    elem_in = '0; elem_eof = 2'b00; vec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_enqueue", enqueue, 0);
    check("rst_eof", eof_out, 0);
    check("rst_vector", vector_out, 0);
    check("rst_fill", fill_level, 0);
    check("rst_count", vec_count, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full vector 1..8
    for (int i = 1; i <= 8; i++) send(DW'(i), 2'b00);
    check("t1_latency", enqueue, 1);
    @(posedge clk); #1;
    check("t1_one_cycle", enqueue, 0);
    check("t1_count", vec_count, 1);

    // Early close with eof 01, then lane 0 restart with eof on lane N-1
    send(32'hA, 2'b00); send(32'hB, 2'b00); send(32'hC, 2'b01);
    check("t2_fill", fill_level, 0);
    check("t2_enqueue", enqueue, 1);
    for (int i = 0; i < 8; i++) send(32'hD0 + DW'(i), (i == 7) ? 2'b10 : 2'b00);
    // Single-element frame
    send(32'h55, 2'b11);
    @(posedge clk); #1;

    // Backpressure hold for 5 cycles
    for (int i = 0; i < 8; i++) send(32'h100 + DW'(i), 2'b00);
    vec_ready = 1'b0; elem_valid = 1'b1; elem_in = 32'hDEAD; elem_eof = 2'b00;
    held = vector_out; c0 = vec_count;
    repeat (5) begin
      @(negedge clk);
      check("t3_enqueue", enqueue, 1);
      check("t3_stable", vector_out, held);
      check("t3_ready", elem_ready, 0);
      check("t3_count", vec_count, c0);
    end
    @(posedge clk); #1;
    vec_ready = 1'b1; elem_valid = 1'b0;
    @(posedge clk); #1;
    check("t3_xfer", vec_count, c0 + 16'd1);
    check("t3_drained", enqueue, 0);

    // 16 back-to-back elements
    c0 = vec_count; t0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      send(32'h200 + DW'(k), 2'b00);
      if (k == 8 || k == 16) check("t4_enqueue", enqueue, 1);
      else if (k > 8) check("t4_gap", enqueue, 0);
    end
    check("t4_cycles", cyc - t0, 16);
    @(posedge clk); #1;
    check("t4_count", vec_count, c0 + 16'd2);

    // Reset mid-vector
    for (int k = 0; k < 5; k++) send(32'h300 + DW'(k), 2'b00);
    reset_n = 1'b0;
    #1;
    check("t5_enqueue", enqueue, 0);
    check("t5_fill", fill_level, 0);
    tb_idx = 0; sbq.delete(); exp_count = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) send(32'h10 + DW'(k), 2'b00);
    @(posedge clk); #1;
    check("t5_count", vec_count, 1);

    // Tracing pause with a partial accumulator
    for (int k = 0; k < 4; k++) send(32'h400 + DW'(k), 2'b00);
    tracing = 1'b0; elem_valid = 1'b1; elem_in = 32'hBAD; elem_eof = 2'b01;
    repeat (10) begin
      @(negedge clk);
      check("t6_ready", elem_ready, 0);
      check("t6_fill", fill_level, 4);
    end
    @(posedge clk); #1;
    tracing = 1'b1; elem_valid = 1'b0;
    for (int k = 4; k < 8; k++) send(32'h400 + DW'(k), 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("t6_count", vec_count, 2);
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_assembler.md
Name: vector_assembler

Overview:
- Producer-side front end for the input buffer: collects a scalar trace stream, one element per cycle, into N-lane vectors.
- Each completed vector is presented on the input buffer's write interface (enqueue, eof, vector) through a one-entry output register with backpressure.
- Sits between the instrumentation tap and the input buffer.
- Partial vectors closed by an end-of-frame marker are zero-padded.

Parameters:
N, 8, lanes per vector; must match the input buffer's N.
DATA_WIDTH, 32, bits per element.
PAD_VALUE, 0, value written to unfilled lanes of an early-closed vector.
CNT_WIDTH, 16, width of the emitted-vector counter.

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
tracing  input  1  1 = accept elements; 0 = stop accepting (reconfiguration window)
elem_valid  input  1  source element valid
elem_in  input  DATA_WIDTH  source element
elem_eof  input  2  end-of-frame code for this element; nonzero closes the current vector
elem_ready  output  1  assembler accepts elem_in this cycle
vec_ready  input  1  downstream can take a vector this cycle (input buffer not full)
enqueue  output  1  vector_out/eof_out valid; transfer occurs when enqueue & vec_ready
eof_out  output  2  eof code of the presented vector; 00 when enqueue=0
vector_out  output  N x DATA_WIDTH  presented vector; lane 0 = first element accepted
fill_level  output  clog2(N)+1  lanes currently held in the accumulator (0..N-1)
vec_count  output  CNT_WIDTH  vectors transferred since reset, saturating

Behaviour:
- Reset (async, reset_n=0): fill index=0, accumulator lanes=PAD_VALUE, enqueue=0, eof_out=00, vector_out all 0, vec_count=0. Release is synchronous to clk.
- Accept rule: accept = elem_valid & elem_ready. elem_ready = tracing & (!enqueue | vec_ready), combinational.
- On accept:
  - elem_in is written to lane[fill index].
  - If fill index==N-1 or elem_eof!=00, the vector closes.
  - Otherwise the fill index increments.
- Close:
  - The output register loads accumulator lanes 0..idx with the new element in lane idx; lanes idx+1..N-1 get PAD_VALUE.
  - eof_out <= elem_eof; enqueue <= 1 on the next edge. Latency: last element accepted in cycle t, enqueue=1 in cycle t+1.
  - Same edge: fill index <= 0 and accumulator lanes cleared to PAD_VALUE.
- Output register states: EMPTY (enqueue=0) and FULL (enqueue=1).
  - FULL & vec_ready: transfer; vec_count increments (holds at all ones).
  - After a transfer, the state goes to EMPTY unless a close occurs on the same edge; then it stays FULL with the new vector (back-to-back, no bubble).
  - FULL & !vec_ready: vector_out, eof_out and enqueue stay stable; elem_ready=0.
- Throughput: with vec_ready held at 1, one element per cycle, and one vector every N cycles.
- eof_out is driven 00 whenever enqueue=0, matching the input buffer's eof convention.
- tracing=0:
  - No accepts.
  - A partial accumulator is retained, and fill_level is unchanged.
  - A pending output vector still drains on vec_ready.
  - Accumulation resumes at the retained index when tracing returns to 1.
- Single-element frame (elem_eof!=00 at fill index 0): the vector has lane 0 = element and the remaining lanes PAD_VALUE.
- elem_eof on lane N-1: closes normally and carries that code.
- Reset mid-operation: partial and pending vectors are discarded; no enqueue is produced for them.

Test Plan:
- vec_ready=1, 8 elements 1..8, eof 00 -> one cycle later enqueue=1 for exactly one cycle, vector_out=[1..8] (lane0=1), eof_out=00, vec_count=1.
- 3 elements 0xA,0xB,0xC, third with eof 01 -> vector [A,B,C,0,0,0,0,0], eof_out=01, fill_level back to 0; next element lands in lane 0.
- Full vector pending, vec_ready=0 for 5 cycles -> enqueue held high, vector_out stable, elem_ready=0 all 5 cycles, vec_count unchanged; vec_ready=1 -> one transfer, vec_count+1.
- 16 consecutive elements, vec_ready=1 -> enqueue high in cycles 9 and 17 relative to the first accept (cycle 1), no bubbles, vec_count=2.
- reset_n low after 5 accepted elements -> enqueue=0 and fill_level=0 immediately; next 8 elements 0x10..0x17 yield a clean vector [0x10..0x17].
- tracing=0 after 4 elements for 10 cycles with elem_valid=1 -> elem_ready=0 and fill_level=4; tracing=1 plus 4 more elements -> one vector with all 8 lanes in order.
